// File: rtl/fft16_stream_core.sv
// Streaming 16-point radix-2 DIT FFT: bit-reversed load, in-place compute with a
// single butterfly per clock, natural-order unload scaled by 1/16.
module fft16_stream_core #(
  parameter int unsigned N_POINTS = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned TW_W     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_data_valid,
  input  logic [2*DATA_W-1:0]   i_data,
  output logic                  o_data_ready,
  output logic                  o_data_valid,
  output logic [2*DATA_W-1:0]   o_data,
  input  logic                  i_data_ready
);

  localparam int unsigned SW  = 2 * DATA_W;
  localparam int unsigned PW  = DATA_W + TW_W;
  localparam int unsigned TFW = PW + 1;
  localparam int unsigned TSW = DATA_W + 2;
  localparam int unsigned ASW = DATA_W + 3;

  typedef enum logic [1:0] {StLoad, StCompute, StUnload} state_e;

  state_e         state_q, state_d;
  logic [3:0]     load_cnt_q, load_cnt_d;
  logic [4:0]     bfly_cnt_q, bfly_cnt_d;
  logic [3:0]     out_cnt_q, out_cnt_d;
  logic           ready_q, ready_d;
  logic           valid_q, valid_d;
  logic [SW-1:0]  dout_q, dout_d;
  logic           load_we, bfly_we;

  logic [SW-1:0]  mem [N_POINTS];

  // Butterfly addressing
  logic [1:0] stage;
  logic [2:0] j, m, grp, tw_k;
  logic [3:0] span, idx_a, idx_b, load_addr;

  always_comb begin
    stage     = bfly_cnt_q[4:3];
    j         = bfly_cnt_q[2:0];
    span      = 4'd1 << stage;
    m         = j & 3'(span - 4'd1);
    grp       = j >> stage;
    idx_a     = (({1'b0, grp} << stage) << 1) | {1'b0, m};
    idx_b     = idx_a | span;
    tw_k      = m << (2'd3 - stage);
    load_addr = {load_cnt_q[0], load_cnt_q[1], load_cnt_q[2], load_cnt_q[3]};
  end

  // W[k] = cos(2*pi*k/16) - j*sin(2*pi*k/16), Q1.14
  logic signed [TW_W-1:0] w_re, w_im;

  always_comb begin
    w_re = TW_W'(16384);
    w_im = TW_W'(0);
    unique case (tw_k)
      3'd0: begin w_re = TW_W'(16384);  w_im = TW_W'(0);      end
      3'd1: begin w_re = TW_W'(15137);  w_im = TW_W'(-6270);  end
      3'd2: begin w_re = TW_W'(11585);  w_im = TW_W'(-11585); end
      3'd3: begin w_re = TW_W'(6270);   w_im = TW_W'(-15137); end
      3'd4: begin w_re = TW_W'(0);      w_im = TW_W'(-16384); end
      3'd5: begin w_re = TW_W'(-6270);  w_im = TW_W'(-15137); end
      3'd6: begin w_re = TW_W'(-11585); w_im = TW_W'(-11585); end
      3'd7: begin w_re = TW_W'(-15137); w_im = TW_W'(-6270);  end
      default: ;
    endcase
  end

  function automatic logic [DATA_W-1:0] sat(input logic signed [ASW-1:0] v);
    logic signed [ASW-1:0] hi, lo;
    hi = ASW'((2 ** (DATA_W - 1)) - 1);
    lo = -hi - ASW'(1);
    if (v > hi) return {1'b0, {(DATA_W - 1){1'b1}}};
    else if (v < lo) return {1'b1, {(DATA_W - 1){1'b0}}};
    else return v[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
  logic signed [TFW-1:0]    t_re_full, t_im_full;
  logic signed [TSW-1:0]    t_re, t_im;
  logic signed [ASW-1:0]    sum_re, sum_im, dif_re, dif_im;
  logic [SW-1:0]            new_a, new_b;

  always_comb begin
    a_re      = mem[idx_a][SW-1:DATA_W];
    a_im      = mem[idx_a][DATA_W-1:0];
    b_re      = mem[idx_b][SW-1:DATA_W];
    b_im      = mem[idx_b][DATA_W-1:0];
    p_rr      = PW'(b_re) * PW'(w_re);
    p_ii      = PW'(b_im) * PW'(w_im);
    p_ri      = PW'(b_re) * PW'(w_im);
    p_ir      = PW'(b_im) * PW'(w_re);
    t_re_full = TFW'(p_rr) - TFW'(p_ii);
    t_im_full = TFW'(p_ri) + TFW'(p_ir);
    t_re      = TSW'(t_re_full >>> 14);
    t_im      = TSW'(t_im_full >>> 14);
    sum_re    = ASW'(a_re) + ASW'(t_re);
    sum_im    = ASW'(a_im) + ASW'(t_im);
    dif_re    = ASW'(a_re) - ASW'(t_re);
    dif_im    = ASW'(a_im) - ASW'(t_im);
    new_a     = {sat(sum_re >>> 1), sat(sum_im >>> 1)};
    new_b     = {sat(dif_re >>> 1), sat(dif_im >>> 1)};
  end

  // Sample memory has no reset; contents are rebuilt by every frame load.
  always_ff @(posedge i_clk) begin
    if (load_we) mem[load_addr] <= i_data;
    if (bfly_we) begin
      mem[idx_a] <= new_a;
      mem[idx_b] <= new_b;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    bfly_cnt_d = bfly_cnt_q;
    out_cnt_d  = out_cnt_q;
    ready_d    = ready_q;
    valid_d    = valid_q;
    dout_d     = dout_q;
    load_we    = 1'b0;
    bfly_we    = 1'b0;
    unique case (state_q)
      StLoad: begin
        ready_d = 1'b1;
        if (i_data_valid && ready_q) begin
          load_we    = 1'b1;
          load_cnt_d = load_cnt_q + 4'd1;
          if (load_cnt_q == 4'd15) begin
            ready_d    = 1'b0;
            bfly_cnt_d = '0;
            state_d    = StCompute;
          end
        end
      end
      StCompute: begin
        bfly_we    = 1'b1;
        bfly_cnt_d = bfly_cnt_q + 5'd1;
        if (bfly_cnt_q == 5'd31) begin
          // mem[0] is final by now; the last butterfly only touches bins 7 and 15.
          state_d   = StUnload;
          valid_d   = 1'b1;
          dout_d    = mem[0];
          out_cnt_d = '0;
        end
      end
      StUnload: begin
        if (valid_q && i_data_ready) begin
          if (out_cnt_q == 4'd15) begin
            valid_d    = 1'b0;
            ready_d    = 1'b1;
            load_cnt_d = '0;
            state_d    = StLoad;
          end else begin
            out_cnt_d = out_cnt_q + 4'd1;
            dout_d    = mem[out_cnt_q + 4'd1];
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StLoad;
      load_cnt_q <= '0;
      bfly_cnt_q <= '0;
      out_cnt_q  <= '0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      bfly_cnt_q <= bfly_cnt_d;
      out_cnt_q  <= out_cnt_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      dout_q     <= dout_d;
    end
  end

  assign o_data_ready = ready_q;
  assign o_data_valid = valid_q;
  assign o_data       = dout_q;

endmodule

// File: tb/tb_fft16_stream_core.sv
// Bench for fft16_stream_core: directed frames plus random frames checked against a
// fixed-point DIT reference model built from plain loops over stages and groups.
module tb_fft16_stream_core;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_data_valid;
  logic [31:0] i_data;
  logic        o_data_ready;
  logic        o_data_valid;
  logic [31:0] o_data;
  logic        i_data_ready;

  fft16_stream_core dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data_valid (i_data_valid),
    .i_data       (i_data),
    .o_data_ready (o_data_ready),
    .o_data_valid (o_data_valid),
    .o_data       (o_data),
    .i_data_ready (i_data_ready)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] frame_in [16];
  logic [31:0] exp_out  [16];
  logic [31:0] got_out  [16];

  int cos_t [8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
  int sin_t [8] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int bitrev4(input int n);
    return ((n & 1) << 3) | ((n & 2) << 1) | ((n & 4) >> 1) | ((n & 8) >> 3);
  endfunction

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic ref_model();
    int re [16];
    int im [16];
    int span, k, ar, ai, br, bi, wr, wi;
    longint tr, ti;
    for (int n = 0; n < 16; n++) begin
      logic [31:0] s;
      s = frame_in[n];
      re[bitrev4(n)] = int'($signed(s[31:16]));
      im[bitrev4(n)] = int'($signed(s[15:0]));
    end
    for (int st = 0; st < 4; st++) begin
      span = 1 << st;
      for (int g = 0; g < 16; g += 2 * span) begin
        for (int mm = 0; mm < span; mm++) begin
          k  = mm * (8 >> st);
          ar = re[g + mm];
          ai = im[g + mm];
          br = re[g + mm + span];
          bi = im[g + mm + span];
          wr = cos_t[k];
          wi = -sin_t[k];
          tr = (longint'(br) * wr - longint'(bi) * wi) >>> 14;
          ti = (longint'(br) * wi + longint'(bi) * wr) >>> 14;
          re[g + mm]        = sat16((longint'(ar) + tr) >>> 1);
          im[g + mm]        = sat16((longint'(ai) + ti) >>> 1);
          re[g + mm + span] = sat16((longint'(ar) - tr) >>> 1);
          im[g + mm + span] = sat16((longint'(ai) - ti) >>> 1);
        end
      end
    end
    for (int n = 0; n < 16; n++) begin
      int r, q;
      r = re[n];
      q = im[n];
      exp_out[n] = {r[15:0], q[15:0]};
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_frame(input bit gappy);
    int  n = 0;
    int  cyc = 0;
    bit  acc;
    while (n < 16 && cyc < 1000) begin
      i_data_valid = gappy ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_data       = i_data_valid ? frame_in[n] : $urandom();
      acc          = i_data_valid && o_data_ready;
      @(posedge i_clk);
      #1;
      cyc++;
      if (acc) n++;
    end
    i_data_valid = 1'b0;
    i_data       = '0;
    if (n < 16) check_eq("load_timeout", 32'(n), 32'd16);
  endtask

  task automatic wait_output(input bit check_lat);
    int c = 0;
    do begin
      @(posedge i_clk);
      #1;
      c++;
      check_eq("ready_low_compute", 32'(o_data_ready), 32'd0);
    end while (!o_data_valid && c < 100);
    if (check_lat) check_eq("latency", 32'(c), 32'd32);
    check_eq("first_valid", 32'(o_data_valid), 32'd1);
  endtask

  task automatic recv_frame(input int stall_bin, input bit random_bp);
    int          idx = 0;
    int          cyc = 0;
    int          stall = 0;
    bit          rdy;
    logic [31:0] held;
    held = '0;
    while (idx < 16 && cyc < 2000) begin
      rdy = 1'b1;
      if (idx == stall_bin && stall < 5) begin
        rdy = 1'b0;
        if (stall == 0) held = o_data;
        else check_eq("hold_stall", o_data, held);
        stall++;
      end else if (random_bp) begin
        rdy = ($urandom_range(0, 1) == 1);
      end
      i_data_ready = rdy;
      check_eq("ready_low_unload", 32'(o_data_ready), 32'd0);
      if (rdy && o_data_valid) begin
        got_out[idx] = o_data;
        idx++;
      end
      @(posedge i_clk);
      #1;
      cyc++;
    end
    i_data_ready = 1'b0;
    check_eq("recv_count", 32'(idx), 32'd16);
    check_eq("valid_drop", 32'(o_data_valid), 32'd0);
    check_eq("ready_back", 32'(o_data_ready), 32'd1);
  endtask

  task automatic run_frame(input bit gappy, input int stall_bin, input bit random_bp,
                           input bit check_lat);
    send_frame(gappy);
    wait_output(check_lat);
    recv_frame(stall_bin, random_bp);
  endtask

  task automatic compare_frame(input string name);
    for (int i = 0; i < 16; i++) check_eq($sformatf("%s_bin%0d", name, i), got_out[i], exp_out[i]);
  endtask

  task automatic load_impulse();
    for (int i = 0; i < 16; i++) begin
      frame_in[i] = (i == 0) ? 32'h4000_0000 : 32'h0;
      exp_out[i]  = 32'h0400_0000;
    end
  endtask

  task automatic load_random(input int amp);
    for (int i = 0; i < 16; i++) begin
      int r, q;
      r = int'($urandom_range(0, 2 * amp)) - amp;
      q = int'($urandom_range(0, 2 * amp)) - amp;
      frame_in[i] = {r[15:0], q[15:0]};
    end
    ref_model();
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_data_valid = 1'b0;
    i_data       = '0;
    i_data_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_ready", 32'(o_data_ready), 32'd0);
    check_eq("rst_valid", 32'(o_data_valid), 32'd0);
    check_eq("rst_data", o_data, 32'h0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check_eq("ready_after_rst", 32'(o_data_ready), 32'd1);

    load_impulse();
    run_frame(1'b0, -1, 1'b0, 1'b1);
    compare_frame("impulse");

    for (int i = 0; i < 16; i++) begin
      frame_in[i] = 32'h0640_0000;
      exp_out[i]  = (i == 0) ? 32'h0640_0000 : 32'h0;
    end
    run_frame(1'b0, -1, 1'b0, 1'b1);
    compare_frame("dc");

    for (int i = 0; i < 16; i++) begin
      frame_in[i] = (i % 2 == 0) ? 32'h0640_0000 : 32'hF9C0_0000;
      exp_out[i]  = (i == 8) ? 32'h0640_0000 : 32'h0;
    end
    run_frame(1'b0, -1, 1'b0, 1'b1);
    compare_frame("alt");

    load_random(20000);
    run_frame(1'b1, 3, 1'b0, 1'b0);
    compare_frame("gappy_stall");

    for (int f = 0; f < 3; f++) begin
      load_random((f == 2) ? 32768 : 4000);
      run_frame(1'b1, -1, 1'b1, 1'b0);
      compare_frame($sformatf("rand%0d", f));
    end

    for (int i = 0; i < 16; i++) frame_in[i] = 32'h7FFF_7FFF;
    run_frame(1'b0, -1, 1'b0, 1'b1);
    check_eq("sat_bin0", got_out[0], 32'h7FFF_7FFF);
    for (int i = 1; i < 16; i++) begin
      int r, q;
      r = int'($signed(got_out[i][31:16]));
      q = int'($signed(got_out[i][15:0]));
      check_eq($sformatf("sat_bin%0d_small", i),
               32'((r >= -2 && r <= 2 && q >= -2 && q <= 2) ? 1 : 0), 32'd1);
    end

    load_random(10000);
    send_frame(1'b0);
    repeat (10) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    check_eq("abort_valid", 32'(o_data_valid), 32'd0);
    check_eq("abort_data", o_data, 32'h0);
    check_eq("abort_ready", 32'(o_data_ready), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check_eq("abort_ready_back", 32'(o_data_ready), 32'd1);
    load_impulse();
    run_frame(1'b0, -1, 1'b0, 1'b1);
    compare_frame("post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
